// File: rtl/seq_generator.sv
// Serial pattern generator: shifts PATTERN out MSB-first `count` times,
// with GAP idle cycles between repetitions and a one-cycle done pulse at the end.
module seq_generator #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b0111,
    parameter int             GAP     = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             ready,
    output logic             d,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W      = (W > 1) ? $clog2(W) : 1;
    localparam int GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   bit_idx_reg, bit_idx_next;
    logic [IDX_W-1:0]   bit_idx_inc;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0]   remaining_reg, remaining_next;
    logic               d_reg, d_next;
    logic               d_valid_reg, d_valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // Bit-reversed copy of the pattern so the bit index counts up from 0 at the MSB.
    logic [W-1:0] pat_rev;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rev
            assign pat_rev[gi] = PATTERN[W-1-gi];
        end
    endgenerate

    assign bit_idx_inc = bit_idx_reg + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_idx_reg   <= '0;
            gap_cnt_reg   <= '0;
            remaining_reg <= '0;
            d_reg         <= 1'b1;
            d_valid_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_idx_reg   <= bit_idx_next;
            gap_cnt_reg   <= gap_cnt_next;
            remaining_reg <= remaining_next;
            d_reg         <= d_next;
            d_valid_reg   <= d_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Outputs are computed for the state being entered, so they line up with it after the edge.
    always_comb begin
        state_next     = state_reg;
        bit_idx_next   = bit_idx_reg;
        gap_cnt_next   = gap_cnt_reg;
        remaining_next = remaining_reg;
        d_next         = 1'b1;
        d_valid_next   = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !abort && (count != '0)) begin
                    state_next     = ST_SHIFT;
                    remaining_next = count;
                    bit_idx_next   = '0;
                    gap_cnt_next   = '0;
                    d_next         = pat_rev[0];
                    d_valid_next   = 1'b1;
                    busy_next      = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    bit_idx_next = '0;
                    gap_cnt_next = '0;
                end else if (bit_idx_reg == IDX_LAST) begin
                    bit_idx_next = '0;
                    if (remaining_reg == CNT_ONE) begin
                        state_next     = ST_DONE;
                        remaining_next = '0;
                        done_next      = 1'b1;
                    end else begin
                        remaining_next = remaining_reg - CNT_ONE;
                        busy_next      = 1'b1;
                        if (GAP > 0) begin
                            state_next   = ST_GAP;
                            gap_cnt_next = '0;
                        end else begin
                            d_next       = pat_rev[0];
                            d_valid_next = 1'b1;
                        end
                    end
                end else begin
                    bit_idx_next = bit_idx_inc;
                    d_next       = pat_rev[bit_idx_inc];
                    d_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = '0;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next   = ST_SHIFT;
                    gap_cnt_next = '0;
                    bit_idx_next = '0;
                    d_next       = pat_rev[0];
                    d_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                    busy_next    = 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_reg == ST_IDLE);
    assign d       = d_reg;
    assign d_valid = d_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: a timeline model predicts every pattern bit and
// done pulse by cycle number; a negedge monitor pops and compares what the DUT presents.
module tb_seq_generator;

    localparam int W     = 4;
    localparam int GAP   = 1;
    localparam int CNT_W = 8;
    localparam int PAT   = 7;   // 4'b0111

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             ready;
    logic             d;
    logic             d_valid;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    seq_generator #(
        .W       (W),
        .PATTERN (4'b0111),
        .GAP     (GAP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .count   (count),
        .abort   (abort),
        .ready   (ready),
        .d       (d),
        .d_valid (d_valid),
        .busy    (busy),
        .done    (done)
    );

    // val: 0/1 = expected pattern bit with d_valid, 2 = expected done pulse
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   busy_from = 0;
    int   busy_to   = -1;
    int   idle_from = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    // Model of one input cycle: timeline arithmetic only.
    function automatic void model_update(logic rst, logic st, int cnt, logic ab);
        bit active;
        bit idle;
        int done_cyc;
        if (rst) begin
            while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
            if (busy_to >= cyc) busy_to = cyc - 1;
            if (idle_from > cyc) idle_from = cyc;
            return;
        end
        active = (cyc >= busy_from) && (cyc <= busy_to);
        idle   = !((cyc >= busy_from) && (cyc < idle_from));
        if (ab && active) begin
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
            busy_to   = cyc;
            idle_from = cyc + 1;
        end else if (st && !ab && cnt != 0 && idle) begin
            for (int r = 0; r < cnt; r++)
                for (int b = 0; b < W; b++)
                    sb.push_back('{cyc + 1 + r * (W + GAP) + b, (PAT >> (W - 1 - b)) & 1});
            done_cyc = cyc + cnt * W + (cnt - 1) * GAP + 1;
            sb.push_back('{done_cyc, 2});
            busy_from = cyc + 1;
            busy_to   = done_cyc - 1;
            idle_from = done_cyc + 1;
        end
    endfunction

    task automatic step(input logic rst, input logic st, input int cnt, input logic ab);
        @(posedge clk);
        #1;
        reset = rst;
        start = st;
        count = CNT_W'(cnt);
        abort = ab;
        model_update(rst, st, cnt, ab);
        if (rst) begin
            #1;
            check("rst_d", int'(d), 1);
            check("rst_d_valid", int'(d_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_ready", int'(ready), 1);
        end
        $display("cycle %0d: reset=%0d start=%0d count=%0d abort=%0d pending=%0d",
                 cyc, rst, st, cnt, ab, sb.size());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("busy", int'(busy), int'((cyc >= busy_from) && (cyc <= busy_to)));
            check("ready", int'(ready), int'(!((cyc >= busy_from) && (cyc < idle_from))));
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (d_valid || done) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    check("unexpected_output_next_expected", cyc, (sb.size() > 0) ? sb[0].cyc : -1);
                end else begin
                    e = sb.pop_front();
                    if (e.val == 2) begin
                        check("done", int'(done), 1);
                        check("d_valid_at_done", int'(d_valid), 0);
                        check("d_at_done", int'(d), 1);
                    end else begin
                        check("d_valid", int'(d_valid), 1);
                        check("done_during_bits", int'(done), 0);
                        check("d_bit", int'(d), e.val);
                    end
                end
            end else begin
                check("idle_d", int'(d), 1);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        start = 1'b0;
        count = '0;
        abort = 1'b0;

        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        // Release and request in the same cycle: first edge after release accepts.
        step(1'b0, 1'b1, 1, 1'b0);
        idle_cycles(7);

        // Three repetitions with gaps.
        step(1'b0, 1'b1, 3, 1'b0);
        idle_cycles(16);

        // Abort at k+6, then a fresh single-repetition request.
        step(1'b0, 1'b1, 3, 1'b0);
        idle_cycles(5);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 1, 1'b0);
        idle_cycles(7);

        // count==0 ignored; start pulses while busy ignored.
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3, 1'b0);
        idle_cycles(5);

        // Abort and start together in IDLE: abort wins.
        step(1'b0, 1'b1, 2, 1'b1);
        idle_cycles(2);

        // Abort during a gap cycle.
        step(1'b0, 1'b1, 2, 1'b0);
        idle_cycles(4);
        step(1'b0, 1'b0, 0, 1'b1);
        idle_cycles(2);

        // Reset mid-shift at bit index 2, then a clean request after release.
        step(1'b0, 1'b1, 3, 1'b0);
        idle_cycles(2);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1, 1'b0);
        idle_cycles(7);

        // Maximum count, with abort arriving in the DONE cycle (no effect).
        step(1'b0, 1'b1, 255, 1'b0);
        idle_cycles(255 * W + 254 * GAP);
        step(1'b0, 1'b0, 0, 1'b1);
        idle_cycles(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step(1'b0, ($urandom % 3) == 0, $urandom_range(0, 3), ($urandom % 30) == 0);

        guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            step(1'b0, 1'b0, 0, 1'b0);
            guard++;
        end
        idle_cycles(2);
        check("drain_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
